seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes one shared 8-bit seven-segment bus across NUM_DIGITS common-anode digits.
- Holds a frame-coherent shadow copy of the displayed value, so updates never tear mid-frame.
- Sits between the counter/datapath that produces a hex value and the board's seg/anode pins.
- Sequences digit slots with a prescaler and inserts an anode-off guard interval at the start of each slot to prevent ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 50000: clocks per digit slot; must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 2: guard clocks at the start of each slot with all anodes off; legal range ≥ 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = least significant).
- dp_in  in  NUM_DIGITS  decimal point request per digit, active high.
- load  in  1  one-cycle strobe; captures value, dp_in and blank_lz.
- blank_lz  in  1  leading-zero blanking enable, captured with load.
- seg  out  8  segments, active low; seg[6:0]=g..a, seg[7]=dp.
- an  out  NUM_DIGITS  anodes, active low, one-hot-low when driving.
- digit_idx  out  ceil(log2(NUM_DIGITS))  current slot index.
- frame_done  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - seg=8'hFF, an=all ones, digit_idx=0, frame_done=0.
  - prescaler cnt=0.
  - shadow and staged registers = 0, pending=0.
- rst has priority over all other activity, including mid-slot and mid-frame.
- Prescaler:
  - cnt increments 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx increments; idx wraps from NUM_DIGITS-1 to 0.
- Frame boundary (cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1), on the next edge:
  - idx=0, cnt=0, frame_done=1 for exactly one cycle.
  - If pending=1: shadow<=staged, pending<=0.
- Load handling:
  - load outside a boundary cycle: staged<={value,dp_in,blank_lz}, pending<=1. A later load before the boundary overwrites staged (last wins).
  - load in the boundary cycle: shadow takes the new inputs directly (bypass), pending<=0.
- Slot phases, computed from the current (idx, cnt) and registered onto seg/an with exactly 1 cycle latency:
  - GUARD (cnt < BLANK_CYCLES): an=all ones, seg=8'hFF.
  - DRIVE (cnt ≥ BLANK_CYCLES): an[idx]=0, all other anode bits 1; seg={~dp[idx], dec(nibble[idx])}.
  - With BLANK_CYCLES=0 there is no guard phase.
- Decode, dec[6:0] for nibbles 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - Equivalently, with dp off: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- Leading-zero blanking (shadow blank_lz=1):
  - Digit i is blanked if nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit keeps an=all ones through its DRIVE phase, and its dp is suppressed.
- digit_idx reflects idx with no register delay relative to an/seg. It is registered alongside them.
- Display data comes only from shadow. value changing without load has no effect.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 32 clocks):
- Reset, then 40 clocks idle:
  - seg=FF and an=F for the first 3 output cycles.
  - Then an=E, seg=C0 for 6 cycles; then GUARD; then an=D.
  - frame_done pulses exactly once, 32 cycles after reset release.
- load with value=16'h12AF, dp_in=4'b0100, blank_lz=0, mid-frame:
  - The current frame still shows 0000.
  - The next frame shows, per digit: 0:8E/an=E, 1:88/an=D, 2:24/an=B (dp on, seg=24), 3:F9/an=7.
- load value=16'h0030, blank_lz=1:
  - Digits 3 and 2 have an=F throughout their slots.
  - Digit 1 shows B0; digit 0 shows C0.
  - With value=0000, only digit 0 drives (C0).
- Two loads (16'h1111, then 16'h2222) within one frame: the next frame shows 2222 only.
- load 16'h5555 exactly in the boundary cycle: the frame starting next cycle shows 92 on all digits, and pending stays 0.
- Assert rst for 1 cycle mid-DRIVE of digit 2: next cycle seg=FF, an=F, digit_idx=0, shadow cleared; the display restarts at digit 0 GUARD.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Multiplexed seven-segment display scanner. One shared active-low segment
// bus is time-shared across NUM_DIGITS common-anode digits. Each digit owns
// a slot of REFRESH_DIV clocks. The first BLANK_CYCLES clocks of every slot
// turn all anodes off so the previous digit's pattern does not ghost.
// Displayed data lives in a shadow register that changes only on frame
// boundaries, so a value update never tears in the middle of a frame.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   value      hex nibbles, nibble i -> digit i (digit 0 least significant)
//   dp_in      decimal point request per digit, active high
//   load       one-cycle strobe capturing value, dp_in and blank_lz
//   blank_lz   leading-zero blanking enable, captured with load
//   seg        segments, active low; seg[6:0] = g..a, seg[7] = dp
//   an         anodes, active low, one-hot-low while a digit is driven
//   digit_idx  slot index matching the current seg/an outputs
//   frame_done one-cycle pulse at the start of each frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);

  // Scan position
  logic [CW-1:0] cnt_reg;
  logic [IW-1:0] idx_reg;

  // Data being displayed this frame
  logic [4*NUM_DIGITS-1:0] shadow_val_reg;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg;
  logic                    shadow_blz_reg;

  // Most recent load, waiting for the next frame boundary
  logic [4*NUM_DIGITS-1:0] staged_val_reg;
  logic [NUM_DIGITS-1:0]   staged_dp_reg;
  logic                    staged_blz_reg;
  logic                    pending_reg;

  logic                  slot_end;
  logic                  boundary;
  logic                  in_guard;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'h40;
      4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;
      4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;
      4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;
      4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;
      4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;
      4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;
      4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;
      default: dec7 = 7'h0E;
    endcase
  endfunction

  assign slot_end = (cnt_reg == CW'(REFRESH_DIV - 1));
  assign boundary = slot_end && (idx_reg == IW'(NUM_DIGITS - 1));
  assign in_guard = (BLANK_CYCLES > 0) && (int'(cnt_reg) < BLANK_CYCLES);

  // Per-digit nibble view and leading-zero mask. A digit is a leading zero
  // when it and every more-significant nibble are zero; digit 0 always shows
  // so an all-zero value still displays a single "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = shadow_val_reg[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = shadow_blz_reg & ~(|shadow_val_reg[4*NUM_DIGITS-1:4*gi]);
    end
  end

  assign cur_nib   = nib[idx_reg];
  assign cur_blank = blank[idx_reg];

  always_comb begin
    seg_next = 8'hFF;
    an_next  = '1;
    if (!in_guard) begin
      // A blanked digit keeps its anode off and never lights its dp
      seg_next = {~(shadow_dp_reg[idx_reg] & ~cur_blank), dec7(cur_nib)};
      if (!cur_blank) begin
        an_next = ~(NUM_DIGITS'(1) << idx_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      shadow_blz_reg <= 1'b0;
      staged_val_reg <= '0;
      staged_dp_reg  <= '0;
      staged_blz_reg <= 1'b0;
      pending_reg    <= 1'b0;
      seg            <= 8'hFF;
      an             <= '1;
      digit_idx      <= '0;
      frame_done     <= 1'b0;
    end else begin
      // Prescaler and slot sequencing
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + IW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      frame_done <= boundary;

      // A load landing on the boundary bypasses staging and also discards
      // any older staged value, so the newest data always wins.
      if (boundary && load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp_in;
        shadow_blz_reg <= blank_lz;
        pending_reg    <= 1'b0;
      end else if (boundary && pending_reg) begin
        shadow_val_reg <= staged_val_reg;
        shadow_dp_reg  <= staged_dp_reg;
        shadow_blz_reg <= staged_blz_reg;
        pending_reg    <= 1'b0;
      end else if (load) begin
        staged_val_reg <= value;
        staged_dp_reg  <= dp_in;
        staged_blz_reg <= blank_lz;
        pending_reg    <= 1'b1;
      end

      // Outputs are registered together so digit_idx always labels seg/an
      seg       <= seg_next;
      an        <= an_next;
      digit_idx <= idx_reg;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2 (32-clock frame). Every output cycle is compared against
// hand-computed per-digit patterns for the frame being displayed.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One display image: load inputs plus expected DRIVE-phase seg/an per
  // digit (index = digit). an=F marks a blanked digit; only its dp bit is
  // checked on seg.
  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic             blz;
    logic [3:0][7:0]  seg;
    logic [3:0][3:0]  an;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // posedges since reset release

  function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dp,
                              input logic blz, input logic [31:0] segs,
                              input logic [15:0] ans);
    vec_t v;
    v.value = val;
    v.dp    = dp;
    v.blz   = blz;
    v.seg   = segs;
    v.an    = ans;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  // Outputs at this point reflect scan position t-1 of the frame.
  task automatic check_cycle(input vec_t v);
    int p, slot, c;
    logic [7:0] es;
    logic [3:0] ea;
    p    = (t - 1) % 32;
    slot = p / 8;
    c    = p % 8;
    if (c < 2) begin
      es = 8'hFF;
      ea = 4'hF;
    end else begin
      es = v.seg[slot];
      ea = v.an[slot];
    end
    chk("an", 32'(an), 32'(ea));
    if (c >= 2 && ea == 4'hF) chk("blank_dp", 32'(seg[7]), 32'd1);
    else                      chk("seg", 32'(seg), 32'(es));
    chk("digit_idx", 32'(digit_idx), 32'(slot));
    chk("frame_done", 32'(frame_done), 32'(t % 32 == 0));
  endtask

  task automatic goto_chk(input int target, input vec_t cur);
    for (int k = 0; k < 32; k++) begin
      step();
      check_cycle(cur);
      if (t % 32 == target) break;
    end
  endtask

  task automatic check_frame(input vec_t v);
    for (int k = 0; k < 32; k++) begin
      step();
      check_cycle(v);
    end
  endtask

  // Pulse load for one edge, then scramble the inputs to show they are
  // ignored without a load.
  task automatic do_load(input vec_t nv, input vec_t cur);
    value    = nv.value;
    dp_in    = nv.dp;
    blank_lz = nv.blz;
    load     = 1'b1;
    step();
    check_cycle(cur);
    load     = 1'b0;
    value    = ~nv.value;
    dp_in    = ~nv.dp;
    blank_lz = ~nv.blz;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    t   = 0;
  endtask

  vec_t vt [7];
  vec_t zero_v, v1111, v2222, v7777, v5555, prev;

  initial begin
    zero_v = mk(16'h0000, 4'b0000, 1'b0, 32'hC0_C0_C0_C0, 16'h7BDE);
    vt[0]  = mk(16'h12AF, 4'b0100, 1'b0, 32'hF9_24_88_8E, 16'h7BDE);
    vt[1]  = mk(16'h0030, 4'b0000, 1'b1, 32'hC0_C0_B0_C0, 16'hFFDE);
    vt[2]  = mk(16'h0000, 4'b0000, 1'b1, 32'hC0_C0_C0_C0, 16'hFFFE);
    vt[3]  = mk(16'h4567, 4'b0000, 1'b0, 32'h99_92_82_F8, 16'h7BDE);
    vt[4]  = mk(16'h89BC, 4'b0001, 1'b0, 32'h80_90_83_46, 16'h7BDE);
    vt[5]  = mk(16'hDE0E, 4'b1000, 1'b1, 32'h21_86_C0_86, 16'h7BDE);
    vt[6]  = mk(16'h0005, 4'b1110, 1'b1, 32'hFF_FF_FF_92, 16'hFFFE);
    v1111  = mk(16'h1111, 4'b0000, 1'b0, 32'hF9_F9_F9_F9, 16'h7BDE);
    v2222  = mk(16'h2222, 4'b0000, 1'b0, 32'hA4_A4_A4_A4, 16'h7BDE);
    v7777  = mk(16'h7777, 4'b0000, 1'b0, 32'hF8_F8_F8_F8, 16'h7BDE);
    v5555  = mk(16'h5555, 4'b0000, 1'b0, 32'h92_92_92_92, 16'h7BDE);

    rst      = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);

    // Reset, then 40 idle clocks showing 0000 with one frame_done at t=32
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step();
      check_cycle(zero_v);
    end
    $display("reset/idle: 40 cycles checked, checks=%0d", n_checks);

    // Table: load mid-frame, old image holds to the boundary, new image next
    prev = zero_v;
    for (int i = 0; i < 7; i++) begin
      goto_chk(10, prev);
      do_load(vt[i], prev);
      goto_chk(0, prev);
      check_frame(vt[i]);
      $display("vector %0d: value=%h dp=%b blz=%0d frame checked", i, vt[i].value, vt[i].dp, vt[i].blz);
      prev = vt[i];
    end

    // Two loads in one frame: last one wins
    goto_chk(5, prev);
    do_load(v1111, prev);
    goto_chk(12, prev);
    do_load(v2222, prev);
    goto_chk(0, prev);
    check_frame(v2222);
    $display("double load: 1111 then 2222 frame checked");

    // Staged 7777, then 5555 in the boundary cycle bypasses and drops it
    goto_chk(8, v2222);
    do_load(v7777, v2222);
    goto_chk(31, v2222);
    do_load(v5555, v2222);
    check_frame(v5555);
    check_frame(v5555);
    $display("boundary load: 5555 shown for two frames");

    // Reset while digit 2 is in DRIVE
    goto_chk(20, v5555);
    chk("pre_rst_an", 32'(an), 32'hB);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step();
      check_cycle(zero_v);
    end
    $display("mid-drive reset: restart at digit 0 checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
